// File: rtl/lsu_dmem_if.sv
// -----------------------------------------------------------------------------
// lsu_dmem_if
//
// Memory-side initiator of the load/store unit. It takes one load or store per
// cycle from the execute stage, drives the data-SRAM port, and returns one
// registered writeback response per request, two cycles after acceptance.
//
// The SRAM registers the request on the posedge that ends the accept cycle and
// returns read data combinationally in the following cycle.
//
// Pipeline:
//   cycle N   : request accepted, dat_* driven combinationally from it
//   cycle N+1 : S1 holds the access context, dat_rd is aligned and extended
//   cycle N+2 : response register (S2) presents the result
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   lsu_req_*           request from execute (vld/rdy handshake, we, funct3,
//                       byte address, store data, load destination)
//   lsu_flush           kills every in-flight response, blocks acceptance
//   lsu_rsp_*           writeback response (vld, err, dest reg, data)
//   dat_a/we/wd/re/rd   data-SRAM port (byte address, byte enables, data)
//
// Optional feature (macro LSU_MISALIGN_SPLIT_EN):
//   undefined : any non-naturally aligned halfword/word access is an error
//   defined   : accesses inside one word are done directly; word-crossing
//               accesses are split over two cycles (FSM state SPLIT2) and
//               merged into a single response one cycle later than usual.
// -----------------------------------------------------------------------------
module lsu_dmem_if #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req_vld,
  output logic              lsu_req_rdy,
  input  logic              lsu_req_we,
  input  logic [2:0]        lsu_req_f3,
  input  logic [31:0]       lsu_req_a,
  input  logic [31:0]       lsu_req_wd,
  input  logic [4:0]        lsu_req_rd_a,
  input  logic              lsu_flush,
  output logic              lsu_rsp_vld,
  output logic              lsu_rsp_err,
  output logic [4:0]        lsu_rsp_rd_a,
  output logic [31:0]       lsu_rsp_d,
  output logic [ADDR_W-1:0] dat_a,
  output logic [3:0]        dat_we,
  output logic [31:0]       dat_wd,
  output logic [3:0]        dat_re,
  input  logic [31:0]       dat_rd
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SPLIT2 = 1'b1
  } state_t;

  state_t state_r;
  state_t state_s;

  // Request decode
  logic        rdy_s;
  logic [1:0]  off_s;
  logic [3:0]  mask_s;
  logic [3:0]  lanes_s;
  logic [31:0] wd_sh_s;
  logic [31:0] hi_bits_s;
  logic        f3_err_s;
  logic        range_err_s;
  logic        align_err_s;
  logic        req_err_s;
  logic        accept_s;
  logic        access_s;

  // S1: context of the access whose read data arrives this cycle
  logic        s1_vld_r;
  logic        s1_load_r;
  logic [2:0]  s1_f3_r;
  logic [1:0]  s1_off_r;
  logic [4:0]  s1_rd_a_r;
  logic        s1_err_r;
  logic        s1_rsp_s;
  logic [31:0] aligned_s;
  logic [31:0] ext_s;

  // S2: registered response
  logic        rsp_vld_r;
  logic        rsp_err_r;
  logic [4:0]  rsp_rd_a_r;
  logic [31:0] rsp_d_r;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]        lanes8_s;
  logic [63:0]       wd64_s;
  logic              cross_s;
  logic              split_s;
  logic [ADDR_W-3:0] hold_word_r;
  logic [3:0]        hold_lanes_r;
  logic [31:0]       hold_wd_r;
  logic              s1_split_lo_r;
  logic              s1_split_hi_r;
  logic [31:0]       merge_r;
  logic [63:0]       rd64_s;
`else
  logic              is_half_s;
  logic              is_word_s;
`endif

  // Align-extend a right-justified read word according to the load funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] res;
    case (f3)
      3'd0:    res = {{24{raw[7]}}, raw[7:0]};
      3'd1:    res = {{16{raw[15]}}, raw[15:0]};
      3'd2:    res = raw;
      3'd4:    res = {24'h000000, raw[7:0]};
      3'd5:    res = {16'h0000, raw[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Request decode: lane mask, shifted store data, error classification.
  always_comb begin
    rdy_s  = (state_r == ST_IDLE) && !rst && !lsu_flush;
    off_s  = lsu_req_a[1:0];
    case (lsu_req_f3[1:0])
      2'd0:    mask_s = 4'b0001;
      2'd1:    mask_s = 4'b0011;
      2'd2:    mask_s = 4'b1111;
      default: mask_s = 4'b0000;
    endcase
    // funct3 3 and 7 are never legal; 6 is not a load, 4/5 are not stores
    f3_err_s = (lsu_req_f3[1:0] == 2'd3) ||
               (lsu_req_f3[2] && (lsu_req_we || lsu_req_f3[1]));
    // any address bit above the SRAM window makes the access out of range
    hi_bits_s   = lsu_req_a >> ADDR_W;
    range_err_s = |hi_bits_s;
`ifdef LSU_MISALIGN_SPLIT_EN
    lanes8_s    = {4'b0000, mask_s} << off_s;
    wd64_s      = {32'h0000_0000, lsu_req_wd} << {off_s, 3'b000};
    lanes_s     = lanes8_s[3:0];
    wd_sh_s     = wd64_s[31:0];
    cross_s     = |lanes8_s[7:4];
    // a crossing access in the last word would wrap to address 0
    align_err_s = cross_s && (&lsu_req_a[ADDR_W-1:2]);
`else
    is_half_s   = (lsu_req_f3[1:0] == 2'd1);
    is_word_s   = (lsu_req_f3[1:0] == 2'd2);
    lanes_s     = mask_s << off_s;
    wd_sh_s     = lsu_req_wd << {off_s, 3'b000};
    align_err_s = (is_half_s && off_s[0]) || (is_word_s && (off_s != 2'b00));
`endif
    req_err_s = f3_err_s || range_err_s || align_err_s;
    accept_s  = lsu_req_vld && rdy_s;
    access_s  = accept_s && !req_err_s;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_s   = access_s && cross_s;
`endif
  end

  // Next-state logic: a word-crossing access spends one extra cycle in SPLIT2.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_s) begin
          state_s = ST_SPLIT2;
        end else begin
          state_s = ST_IDLE;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      ST_SPLIT2: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // SRAM port drive: first (or only) part in IDLE, high part in SPLIT2.
  always_comb begin
    dat_a  = {ADDR_W{1'b0}};
    dat_we = 4'b0000;
    dat_re = 4'b0000;
    dat_wd = 32'h0000_0000;
    if (state_r == ST_IDLE) begin
      if (access_s) begin
        dat_a  = lsu_req_a[ADDR_W-1:0];
        dat_wd = wd_sh_s;
        if (lsu_req_we) begin
          dat_we = lanes_s;
        end else begin
          dat_re = lanes_s;
        end
      end else begin
        dat_a = {ADDR_W{1'b0}};
      end
    end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
      // flush or reset in SPLIT2 abandons the second half
      if (!rst && !lsu_flush) begin
        dat_a  = {hold_word_r, 2'b00};
        dat_wd = hold_wd_r;
        if (s1_load_r) begin
          dat_re = hold_lanes_r;
        end else begin
          dat_we = hold_lanes_r;
        end
      end else begin
        dat_a = {ADDR_W{1'b0}};
      end
`else
      dat_a = {ADDR_W{1'b0}};
`endif
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Second-half request captured when a crossing access is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word_r  <= {(ADDR_W-2){1'b0}};
      hold_lanes_r <= 4'b0000;
      hold_wd_r    <= 32'h0000_0000;
    end else if (split_s) begin
      hold_word_r  <= lsu_req_a[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
      hold_lanes_r <= lanes8_s[7:4];
      hold_wd_r    <= wd64_s[63:32];
    end else begin
      hold_word_r  <= hold_word_r;
      hold_lanes_r <= hold_lanes_r;
      hold_wd_r    <= hold_wd_r;
    end
  end

  // Low word of a split load, merged with the high word one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_r <= 32'h0000_0000;
    end else if (s1_vld_r && s1_split_lo_r) begin
      merge_r <= dat_rd;
    end else begin
      merge_r <= merge_r;
    end
  end
`endif

  // S1 register: context of the access issued in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r      <= 1'b0;
      s1_load_r     <= 1'b0;
      s1_f3_r       <= 3'd0;
      s1_off_r      <= 2'd0;
      s1_rd_a_r     <= 5'd0;
      s1_err_r      <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      s1_split_lo_r <= 1'b0;
      s1_split_hi_r <= 1'b0;
`endif
    end else if (lsu_flush) begin
      s1_vld_r      <= 1'b0;
    end else if (accept_s) begin
      s1_vld_r      <= 1'b1;
      s1_load_r     <= !lsu_req_we;
      s1_f3_r       <= lsu_req_f3;
      s1_off_r      <= off_s;
      s1_rd_a_r     <= lsu_req_rd_a;
      s1_err_r      <= req_err_s;
`ifdef LSU_MISALIGN_SPLIT_EN
      s1_split_lo_r <= split_s;
      s1_split_hi_r <= 1'b0;
    end else if (state_r == ST_SPLIT2) begin
      // same access context, now waiting for the high word
      s1_vld_r      <= 1'b1;
      s1_split_lo_r <= 1'b0;
      s1_split_hi_r <= 1'b1;
`endif
    end else begin
      s1_vld_r      <= 1'b0;
    end
  end

  // Read-data alignment for the access in S1.
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    s1_rsp_s  = s1_vld_r && !s1_split_lo_r;
    if (s1_split_hi_r) begin
      rd64_s = {dat_rd, merge_r};
    end else begin
      rd64_s = {32'h0000_0000, dat_rd};
    end
    aligned_s = 32'(rd64_s >> {s1_off_r, 3'b000});
`else
    s1_rsp_s  = s1_vld_r;
    aligned_s = dat_rd >> {s1_off_r, 3'b000};
`endif
    ext_s = load_ext(s1_f3_r, aligned_s);
  end

  // S2 response register: loads return data, stores and errors return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_r  <= 1'b0;
      rsp_err_r  <= 1'b0;
      rsp_rd_a_r <= 5'd0;
      rsp_d_r    <= 32'h0000_0000;
    end else if (lsu_flush) begin
      rsp_vld_r  <= 1'b0;
      rsp_err_r  <= 1'b0;
      rsp_rd_a_r <= 5'd0;
      rsp_d_r    <= 32'h0000_0000;
    end else if (s1_rsp_s) begin
      rsp_vld_r  <= 1'b1;
      rsp_err_r  <= s1_err_r;
      if (s1_load_r && !s1_err_r) begin
        rsp_rd_a_r <= s1_rd_a_r;
        rsp_d_r    <= ext_s;
      end else begin
        rsp_rd_a_r <= 5'd0;
        rsp_d_r    <= 32'h0000_0000;
      end
    end else begin
      rsp_vld_r  <= 1'b0;
      rsp_err_r  <= 1'b0;
      rsp_rd_a_r <= 5'd0;
      rsp_d_r    <= 32'h0000_0000;
    end
  end

  assign lsu_req_rdy  = rdy_s;
  // A response sitting in S2 while flush is raised belongs to the killed
  // window as well, so it is suppressed rather than handed to writeback.
  assign lsu_rsp_vld  = rsp_vld_r && !lsu_flush;
  assign lsu_rsp_err  = rsp_err_r;
  assign lsu_rsp_rd_a = rsp_rd_a_r;
  assign lsu_rsp_d    = rsp_d_r;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if with a small behavioural data SRAM.
module tb_lsu_dmem_if;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_vld;
  logic        lsu_req_rdy;
  logic        lsu_req_we;
  logic [2:0]  lsu_req_f3;
  logic [31:0] lsu_req_a;
  logic [31:0] lsu_req_wd;
  logic [4:0]  lsu_req_rd_a;
  logic        lsu_flush;
  logic        lsu_rsp_vld;
  logic        lsu_rsp_err;
  logic [4:0]  lsu_rsp_rd_a;
  logic [31:0] lsu_rsp_d;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;

  int checks = 0;
  int errors = 0;

  lsu_dmem_if #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_we(lsu_req_we),
    .lsu_req_f3(lsu_req_f3), .lsu_req_a(lsu_req_a), .lsu_req_wd(lsu_req_wd),
    .lsu_req_rd_a(lsu_req_rd_a), .lsu_flush(lsu_flush),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_err(lsu_rsp_err), .lsu_rsp_rd_a(lsu_rsp_rd_a),
    .lsu_rsp_d(lsu_rsp_d),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd)
  );

  always #5 clk = ~clk;

  // SRAM model: request registered at posedge, read data combinational next cycle.
  logic [31:0] mem [0:63];
  logic [5:0]  rd_idx_r = 6'd0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dat_we[i]) mem[dat_a[7:2]][8*i +: 8] <= dat_wd[8*i +: 8];
    end
    if (|dat_re) rd_idx_r <= dat_a[7:2];
  end
  assign dat_rd = mem[rd_idx_r];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs change 1ns after posedge, checks follow 1ns later.
  task automatic cyc(input logic r, input logic fl, input logic v, input logic we,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] rd);
    @(posedge clk);
    #1;
    rst = r; lsu_flush = fl; lsu_req_vld = v; lsu_req_we = we;
    lsu_req_f3 = f3; lsu_req_a = a; lsu_req_wd = wd; lsu_req_rd_a = rd;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; lsu_flush = 1'b0; lsu_req_vld = 1'b0; lsu_req_we = 1'b0;
    lsu_req_f3 = 3'd0; lsu_req_a = 32'h0; lsu_req_wd = 32'h0; lsu_req_rd_a = 5'd0;

    // reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'h0, 5'd1);
    chk("rst_rdy", lsu_req_rdy, 32'd0);
    chk("rst_rsp_vld", lsu_rsp_vld, 32'd0);
    chk("rst_rsp_err", lsu_rsp_err, 32'd0);
    chk("rst_rsp_rd_a", lsu_rsp_rd_a, 32'd0);
    chk("rst_rsp_d", lsu_rsp_d, 32'd0);
    chk("rst_dat_we", dat_we, 32'd0);
    chk("rst_dat_re", dat_re, 32'd0);
    chk("rst_dat_a", dat_a, 32'd0);
    chk("rst_dat_wd", dat_wd, 32'd0);
    idle();
    chk("post_rst_rdy", lsu_req_rdy, 32'd1);
    chk("post_rst_rsp_vld", lsu_rsp_vld, 32'd0);

    // 1: SW then LW same word
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_W, 32'h10, 32'hDEADBEEF, 5'd0);
    chk("t1_sw_we", dat_we, 32'hF);
    chk("t1_sw_a", dat_a, 32'h10);
    chk("t1_sw_wd", dat_wd, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'h0, 5'd5);
    chk("t1_lw_re", dat_re, 32'hF);
    chk("t1_lw_we", dat_we, 32'h0);
    chk("t1_n1_vld", lsu_rsp_vld, 32'd0);
    idle();
    chk("t1_st_vld", lsu_rsp_vld, 32'd1);
    chk("t1_st_rd_a", lsu_rsp_rd_a, 32'd0);
    chk("t1_st_d", lsu_rsp_d, 32'd0);
    chk("t1_st_err", lsu_rsp_err, 32'd0);
    idle();
    chk("t1_ld_vld", lsu_rsp_vld, 32'd1);
    chk("t1_ld_d", lsu_rsp_d, 32'hDEADBEEF);
    chk("t1_ld_rd_a", lsu_rsp_rd_a, 32'd5);

    // 2: byte/half loads with sign and zero extension, back to back
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_W, 32'h20, 32'h80FF7F01, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_B, 32'h23, 32'h0, 5'd1);
    chk("t2_lb_re", dat_re, 32'h8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_BU, 32'h23, 32'h0, 5'd2);
    chk("t2_sw_rsp_vld", lsu_rsp_vld, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_H, 32'h22, 32'h0, 5'd3);
    chk("t2_lh_re", dat_re, 32'hC);
    chk("t2_lb_vld", lsu_rsp_vld, 32'd1);
    chk("t2_lb_d", lsu_rsp_d, 32'hFFFFFF80);
    chk("t2_lb_rd_a", lsu_rsp_rd_a, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_HU, 32'h22, 32'h0, 5'd4);
    chk("t2_lbu_vld", lsu_rsp_vld, 32'd1);
    chk("t2_lbu_d", lsu_rsp_d, 32'h00000080);
    idle();
    chk("t2_lh_vld", lsu_rsp_vld, 32'd1);
    chk("t2_lh_d", lsu_rsp_d, 32'hFFFF80FF);
    idle();
    chk("t2_lhu_vld", lsu_rsp_vld, 32'd1);
    chk("t2_lhu_d", lsu_rsp_d, 32'h000080FF);
    chk("t2_lhu_rd_a", lsu_rsp_rd_a, 32'd4);

    // 3: sub-word stores, lane placement
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_B, 32'h31, 32'h000000AA, 5'd0);
    chk("t3_idle_vld", lsu_rsp_vld, 32'd0);
    chk("t3_sb_we", dat_we, 32'h2);
    chk("t3_sb_wd", dat_wd, 32'h0000AA00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_H, 32'h32, 32'h00001234, 5'd0);
    chk("t3_sh_we", dat_we, 32'hC);
    chk("t3_sh_wd", dat_wd, 32'h12340000);
    idle();
    idle();

    // 4: misaligned word load
`ifdef LSU_MISALIGN_SPLIT_EN
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_W, 32'h10, 32'h44332211, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, F_W, 32'h14, 32'h88776655, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h12, 32'h0, 5'd9);
    chk("t4s_lo_re", dat_re, 32'hC);
    chk("t4s_lo_a", dat_a, 32'h12);
    idle();
    chk("t4s_rdy_low", lsu_req_rdy, 32'd0);
    chk("t4s_hi_re", dat_re, 32'h3);
    chk("t4s_hi_a", dat_a, 32'h14);
    idle();
    chk("t4s_rdy_back", lsu_req_rdy, 32'd1);
    chk("t4s_n2_vld", lsu_rsp_vld, 32'd0);
    idle();
    chk("t4s_vld", lsu_rsp_vld, 32'd1);
    chk("t4s_err", lsu_rsp_err, 32'd0);
    chk("t4s_d", lsu_rsp_d, 32'h66554433);
    chk("t4s_rd_a", lsu_rsp_rd_a, 32'd9);
`else
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h12, 32'h0, 5'd7);
    chk("t4_mis_re", dat_re, 32'h0);
    idle();
    idle();
    chk("t4_mis_vld", lsu_rsp_vld, 32'd1);
    chk("t4_mis_err", lsu_rsp_err, 32'd1);
    chk("t4_mis_rd_a", lsu_rsp_rd_a, 32'd0);
    chk("t4_mis_d", lsu_rsp_d, 32'd0);
`endif
    // out of range, bad load funct3, bad store funct3
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h00010010, 32'h0, 5'd7);
    chk("t4_rng_re", dat_re, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 32'h10, 32'h0, 5'd7);
    chk("t4_f6_re", dat_re, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 32'h10, 32'h0, 5'd0);
    chk("t4_sf4_we", dat_we, 32'h0);
    chk("t4_rng_err", lsu_rsp_err, 32'd1);
    chk("t4_rng_rd_a", lsu_rsp_rd_a, 32'd0);
    idle();
    chk("t4_f6_err", lsu_rsp_err, 32'd1);
    idle();
    chk("t4_sf4_vld", lsu_rsp_vld, 32'd1);
    chk("t4_sf4_err", lsu_rsp_err, 32'd1);
    idle();
    chk("t4_clean_err", lsu_rsp_err, 32'd0);

    // 5: flush kills loads in S1/S2 and blocks the concurrent request
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h10, 32'h0, 5'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h14, 32'h0, 5'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h20, 32'h0, 5'd3);
    chk("t5_first_vld", lsu_rsp_vld, 32'd1);
    chk("t5_first_rd_a", lsu_rsp_rd_a, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, F_W, 32'h30, 32'h0, 5'd4);
    chk("t5_fl_rdy", lsu_req_rdy, 32'd0);
    chk("t5_fl_re", dat_re, 32'h0);
    chk("t5_fl_vld", lsu_rsp_vld, 32'd0);
    idle();
    chk("t5_fl1_vld", lsu_rsp_vld, 32'd0);
    idle();
    chk("t5_fl2_vld", lsu_rsp_vld, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h20, 32'h0, 5'd6);
    idle();
    idle();
    chk("t5_after_vld", lsu_rsp_vld, 32'd1);
    chk("t5_after_d", lsu_rsp_d, 32'h80FF7F01);
    chk("t5_after_rd_a", lsu_rsp_rd_a, 32'd6);

    // 6: reset with a load in S1 drops it
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_W, 32'h20, 32'h0, 5'd7);
    chk("t6_ld_re", dat_re, 32'hF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    chk("t6_rst_rdy", lsu_req_rdy, 32'd0);
    idle();
    chk("t6_vld", lsu_rsp_vld, 32'd0);
    chk("t6_rd_a", lsu_rsp_rd_a, 32'd0);
    chk("t6_d", lsu_rsp_d, 32'd0);
    chk("t6_rdy", lsu_req_rdy, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, F_HU, 32'h22, 32'h0, 5'd8);
    chk("t6_n1_vld", lsu_rsp_vld, 32'd0);
    idle();
    idle();
    chk("t6_rec_vld", lsu_rsp_vld, 32'd1);
    chk("t6_rec_d", lsu_rsp_d, 32'h000080FF);
    chk("t6_rec_rd_a", lsu_rsp_rd_a, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
